// File: rtl/buffer_sched_pkg.sv
// -----------------------------------------------------------------------------
// buffer_sched_pkg
// Shared constants and types for the packet buffer scheduler and the display
// block. It holds the buffer geometry, the slot layout inside a buffer's slot
// vector, and the scheduler FSM state encoding.
//
// Slot layout: slot k of a buffer occupies bits [3k+2:3k] = {data[1:0], valid}.
// Slot 0 is the oldest entry.
// -----------------------------------------------------------------------------
package buffer_sched_pkg;

  localparam int NUM_BUF   = 4;
  localparam int DEPTH     = 6;
  localparam int ENTRY_W   = 3;
  localparam int DATA_W    = 2;
  localparam int OCC_W     = 3;
  localparam int BUF_IDX_W = 2;
  localparam int SLOTS_W   = DEPTH * ENTRY_W;

  // Entry field offsets inside one slot
  localparam int VALID_BIT = 0;
  localparam int DATA_LSB  = 1;
  localparam int DATA_MSB  = 2;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ARB  = 2'd1,
    S_POP  = 2'd2
  } sched_state_e;

  // Build a valid slot entry carrying the given payload
  function automatic entry_t make_entry(input logic [DATA_W-1:0] data);
    entry_t e;
    e                    = '0;
    e[VALID_BIT]         = 1'b1;
    e[DATA_MSB:DATA_LSB] = data;
    return e;
  endfunction

endpackage

// File: rtl/buffer_scheduler_if.sv
// -----------------------------------------------------------------------------
// buffer_scheduler_if
// Bundles the write request and everything the scheduler exports to the
// display block.
//   in_valid / in_buf / in_data : one-cycle write strobe, target buffer, payload
//   buf0_o..buf3_o              : per-buffer slot vectors
//   rd_valid_o / rd_buf_o / rd_data_o : pop pulse and held last-pop info
//   tx_cnt_o / rx_cnt_o / drop_cnt_o  : wrapping packet counters
// Modports: master = producer/display side, slave = scheduler.
// -----------------------------------------------------------------------------
interface buffer_scheduler_if #(
  parameter int CNT_W = 8
);
  import buffer_sched_pkg::*;

  logic                 in_valid;
  logic [BUF_IDX_W-1:0] in_buf;
  logic [DATA_W-1:0]    in_data;

  logic [SLOTS_W-1:0]   buf0_o;
  logic [SLOTS_W-1:0]   buf1_o;
  logic [SLOTS_W-1:0]   buf2_o;
  logic [SLOTS_W-1:0]   buf3_o;

  logic                 rd_valid_o;
  logic [BUF_IDX_W-1:0] rd_buf_o;
  logic [DATA_W-1:0]    rd_data_o;

  logic [CNT_W-1:0]     tx_cnt_o;
  logic [CNT_W-1:0]     rx_cnt_o;
  logic [CNT_W-1:0]     drop_cnt_o;

  modport master (
    output in_valid, in_buf, in_data,
    input  buf0_o, buf1_o, buf2_o, buf3_o,
    input  rd_valid_o, rd_buf_o, rd_data_o,
    input  tx_cnt_o, rx_cnt_o, drop_cnt_o
  );

  modport slave (
    input  in_valid, in_buf, in_data,
    output buf0_o, buf1_o, buf2_o, buf3_o,
    output rd_valid_o, rd_buf_o, rd_data_o,
    output tx_cnt_o, rx_cnt_o, drop_cnt_o
  );

endinterface

// File: rtl/buffer_scheduler_fifo6.sv
// -----------------------------------------------------------------------------
// buffer_fifo6
// One compacted 6-entry shift FIFO. Occupancy n means slots 0..n-1 are valid
// and the rest are all-zero. A same-cycle pop is applied before the push, so a
// full buffer that is popped and pushed together does not drop. A push into a
// full buffer with no pop discards the oldest entry and raises drop_o.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write strobe, push_data : payload
//   pop          : remove the oldest entry (ignored when empty)
//   slots_o      : registered 18-bit slot vector
//   occ_o        : occupancy 0..6, full_o / empty_o : occupancy flags
//   head_data_o  : payload of slot 0
//   drop_o       : push this cycle discards the oldest entry
// -----------------------------------------------------------------------------
module buffer_fifo6
  import buffer_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [SLOTS_W-1:0] slots_o,
  output logic [OCC_W-1:0]   occ_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DATA_W-1:0]  head_data_o,
  output logic               drop_o
);

  entry_t           slot_q [DEPTH];
  entry_t           slot_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_mid_s;
  logic             do_pop_s;

  // Next slot contents: apply pop first, then the push on the compacted result
  always_comb begin
    slot_d    = slot_q;
    occ_d     = occ_q;
    do_pop_s  = pop && (occ_q != 3'd0);
    occ_mid_s = occ_q;
    if (do_pop_s) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slot_d[k] = slot_q[k+1];
      end
      slot_d[DEPTH-1] = '0;
      occ_mid_s       = occ_q - 3'd1;
    end else begin
      occ_mid_s = occ_q;
    end

    if (push) begin
      if (occ_mid_s == OCC_W'(DEPTH)) begin
        // Full with no room: the oldest entry falls off the bottom
        for (int k = 0; k < DEPTH - 1; k++) begin
          slot_d[k] = slot_d[k+1];
        end
        slot_d[DEPTH-1] = make_entry(push_data);
        occ_d           = occ_mid_s;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (OCC_W'(k) == occ_mid_s) begin
            slot_d[k] = make_entry(push_data);
          end else begin
            slot_d[k] = slot_d[k];
          end
        end
        occ_d = occ_mid_s + 3'd1;
      end
    end else begin
      occ_d = occ_mid_s;
    end
  end

  // Drop only happens when a push meets a full buffer that is not popped
  always_comb begin
    drop_o = push && (occ_q == OCC_W'(DEPTH)) && !pop;
  end

  // Flatten the registered slots into the exported vector
  always_comb begin
    slots_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slots_o[k*ENTRY_W +: ENTRY_W] = slot_q[k];
    end
  end

  assign occ_o       = occ_q;
  assign full_o      = (occ_q == OCC_W'(DEPTH));
  assign empty_o     = (occ_q == 3'd0);
  assign head_data_o = slot_q[0][DATA_MSB:DATA_LSB];

  // Slot and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
      occ_q  <= '0;
    end else begin
      slot_q <= slot_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/buffer_scheduler.sv
// -----------------------------------------------------------------------------
// buffer_scheduler
// Four 6-entry packet buffers fed by single-cycle writes and drained one packet
// every READ_PERIOD cycles. FSM: S_WAIT (timer) -> S_ARB (pick a buffer) ->
// S_POP (remove its oldest entry) -> S_WAIT. Writes are accepted in any state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : buffer_scheduler_if.slave (write request in, display data out)
// Parameters: READ_PERIOD (>= 3) cycles between read attempts, CNT_W counter
// width.
// Build option: define BUFFER_SCHED_PRIORITY_READ_EN to arbitrate by highest
// occupancy (ties to lowest index) instead of round-robin.
// -----------------------------------------------------------------------------
module buffer_scheduler
  import buffer_sched_pkg::*;
#(
  parameter int READ_PERIOD = 150000000,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  buffer_scheduler_if.slave  bus
);

  localparam int TMR_W = (READ_PERIOD > 2) ? $clog2(READ_PERIOD) : 2;

  // Per-buffer wiring
  logic [NUM_BUF-1:0] push_s;
  logic [NUM_BUF-1:0] pop_s;
  logic [NUM_BUF-1:0] full_s;
  logic [NUM_BUF-1:0] empty_s;
  logic [NUM_BUF-1:0] drop_s;
  logic [SLOTS_W-1:0] slots_s [NUM_BUF];
  logic [OCC_W-1:0]   occ_s   [NUM_BUF];
  logic [DATA_W-1:0]  head_s  [NUM_BUF];

  // Arbitration result
  logic                 arb_found_s;
  logic [BUF_IDX_W-1:0] arb_idx_s;
  logic                 drop_evt_s;

  // Registered state
  sched_state_e         state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BUF_IDX_W-1:0] sel_q, sel_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [BUF_IDX_W-1:0] rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
`ifndef BUFFER_SCHED_PRIORITY_READ_EN
  logic [BUF_IDX_W-1:0] ptr_q, ptr_d;
`endif

  // Decode write target and pop target into per-buffer strobes
  always_comb begin
    push_s = '0;
    pop_s  = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      push_s[i] = bus.in_valid && (bus.in_buf == BUF_IDX_W'(i));
      // Guard against popping an empty buffer even though arbitration never
      // selects one (writes can only add entries between S_ARB and S_POP)
      pop_s[i]  = (state_q == S_POP) && (sel_q == BUF_IDX_W'(i)) && !empty_s[i];
    end
  end

  for (genvar i = 0; i < NUM_BUF; i++) begin : g_buf
    buffer_fifo6 u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push_s[i]),
      .push_data   (bus.in_data),
      .pop         (pop_s[i]),
      .slots_o     (slots_s[i]),
      .occ_o       (occ_s[i]),
      .full_o      (full_s[i]),
      .empty_o     (empty_s[i]),
      .head_data_o (head_s[i]),
      .drop_o      (drop_s[i])
    );
  end

  // A drop can only originate from a full buffer
  assign drop_evt_s = |(drop_s & full_s);

`ifdef BUFFER_SCHED_PRIORITY_READ_EN
  // Highest occupancy wins; strict compare keeps ties on the lowest index
  always_comb begin
    logic [OCC_W-1:0] best_occ;
    best_occ    = '0;
    arb_idx_s   = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (!empty_s[i] && (occ_s[i] > best_occ)) begin
        best_occ  = occ_s[i];
        arb_idx_s = BUF_IDX_W'(i);
      end else begin
        best_occ  = best_occ;
      end
    end
    arb_found_s = (best_occ != 3'd0);
  end
`else
  // First non-empty buffer at or after the round-robin pointer, modulo 4
  always_comb begin
    logic [BUF_IDX_W-1:0] cand;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      cand = ptr_q + BUF_IDX_W'(k);
      if (!arb_found_s && (occ_s[cand] != 3'd0)) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end
`endif

  // Scheduler FSM next state, pop result capture and counters
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sel_d      = sel_q;
    rd_valid_d = 1'b0;
    rd_buf_d   = rd_buf_q;
    rd_data_d  = rd_data_q;
    tx_cnt_d   = tx_cnt_q;
`ifndef BUFFER_SCHED_PRIORITY_READ_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      S_WAIT: begin
        if (timer_q == TMR_W'(READ_PERIOD - 1)) begin
          timer_d = '0;
          state_d = S_ARB;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ARB: begin
        if (arb_found_s) begin
          sel_d   = arb_idx_s;
          state_d = S_POP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_POP: begin
        rd_valid_d = 1'b1;
        rd_buf_d   = sel_q;
        rd_data_d  = head_s[sel_q];
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
`ifndef BUFFER_SCHED_PRIORITY_READ_EN
        ptr_d      = sel_q + 2'd1;
`endif
        state_d    = S_WAIT;
      end
      default: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
    endcase

    if (bus.in_valid) begin
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end else begin
      rx_cnt_d = rx_cnt_q;
    end

    if (drop_evt_s) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Scheduler state, pop outputs and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      timer_q    <= '0;
      sel_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_buf_q   <= '0;
      rd_data_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
`ifndef BUFFER_SCHED_PRIORITY_READ_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      rd_valid_q <= rd_valid_d;
      rd_buf_q   <= rd_buf_d;
      rd_data_q  <= rd_data_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`ifndef BUFFER_SCHED_PRIORITY_READ_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.buf0_o     = slots_s[0];
  assign bus.buf1_o     = slots_s[1];
  assign bus.buf2_o     = slots_s[2];
  assign bus.buf3_o     = slots_s[3];
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_buf_o   = rd_buf_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.tx_cnt_o   = tx_cnt_q;
  assign bus.rx_cnt_o   = rx_cnt_q;
  assign bus.drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_buffer_scheduler
// Self-checking bench for buffer_scheduler with READ_PERIOD = 8. Expected pops
// are queued as {buf, data} when writes are driven and compared by a monitor
// whenever rd_valid_o pulses; any pop with nothing queued is an error.
// -----------------------------------------------------------------------------
module tb_buffer_scheduler;

  localparam int RP    = 8;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;

  int checks;
  int errors;
  int cyc;
  int first_pop_cyc;
  logic [3:0] exp_q [$];

  buffer_scheduler_if #(.CNT_W(CNT_W)) bus ();

  buffer_scheduler #(
    .READ_PERIOD (RP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle count since reset release; first edge after release reads 1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard monitor: compare each pop against the oldest expected pop
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid_o) begin
      logic [3:0] exp_v;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got buf %0d data %0d, expected no pop",
                 bus.rd_buf_o, bus.rd_data_o);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.rd_buf_o, bus.rd_data_o} !== exp_v) begin
          errors++;
          $display("FAIL pop_item: got buf %0d data %0d, expected buf %0d data %0d",
                   bus.rd_buf_o, bus.rd_data_o, exp_v[3:2], exp_v[1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected slot vector for n entries with payloads d[0..n-1], oldest first
  function automatic logic [17:0] pack(input int n, input logic [1:0] d [6]);
    logic [17:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[3*k +: 3] = {d[k], 1'b1};
    return v;
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_buf   = 2'd0;
    bus.in_data  = 2'd0;
    exp_q.delete();
    first_pop_cyc = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one write so that it is sampled on the next rising edge
  task automatic wr(input logic [1:0] b, input logic [1:0] d);
    bus.in_valid = 1'b1;
    bus.in_buf   = b;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.buf0_o, bus.buf1_o, bus.buf2_o, bus.buf3_o} !== 72'd0) begin
      errors++; $display("FAIL reset_bufs: got nonzero slot vectors, expected all 0");
    end
    checks++;
    if ({bus.rd_valid_o, bus.rd_buf_o, bus.rd_data_o} !== 5'd0) begin
      errors++; $display("FAIL reset_rd: got %b, expected 0", {bus.rd_valid_o, bus.rd_buf_o, bus.rd_data_o});
    end
    checks++;
    if ({bus.tx_cnt_o, bus.rx_cnt_o, bus.drop_cnt_o} !== 24'd0) begin
      errors++; $display("FAIL reset_cnt: got tx %0d rx %0d drop %0d, expected 0",
                         bus.tx_cnt_o, bus.rx_cnt_o, bus.drop_cnt_o);
    end
    repeat (2*RP + 4) @(negedge clk);
    checks++;
    if ({bus.buf0_o, bus.buf1_o, bus.buf2_o, bus.buf3_o} !== 72'd0) begin
      errors++; $display("FAIL idle_bufs: got nonzero slot vectors, expected all 0");
    end
    checks++;
    if ({bus.tx_cnt_o, bus.rx_cnt_o, bus.drop_cnt_o} !== 24'd0) begin
      errors++; $display("FAIL idle_cnt: got tx %0d rx %0d drop %0d, expected 0",
                         bus.tx_cnt_o, bus.rx_cnt_o, bus.drop_cnt_o);
    end
    checks++;
    if (first_pop_cyc != -1) begin
      errors++; $display("FAIL idle_pop: got pop at cycle %0d, expected none", first_pop_cyc);
    end
  endtask

  task automatic test_write_two();
    logic [1:0] d [6];
    do_reset();
    wr(2'd1, 2'd2);
    wr(2'd1, 2'd3);
    d = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    checks++;
    if (bus.buf1_o !== pack(2, d) || bus.buf1_o !== 18'h0003D) begin
      errors++; $display("FAIL write_two_buf1: got %h, expected %h", bus.buf1_o, pack(2, d));
    end
    checks++;
    if ({bus.buf0_o, bus.buf2_o, bus.buf3_o} !== 54'd0) begin
      errors++; $display("FAIL write_two_others: got nonzero, expected 0");
    end
    checks++;
    if (bus.rx_cnt_o !== 8'd2) begin
      errors++; $display("FAIL write_two_rx: got %0d, expected 2", bus.rx_cnt_o);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] d [6];
    do_reset();
    for (int i = 0; i < 7; i++) wr(2'd2, 2'(i % 4));
    d = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    checks++;
    if (bus.buf2_o !== pack(6, d)) begin
      errors++; $display("FAIL overflow_buf2: got %h, expected %h", bus.buf2_o, pack(6, d));
    end
    checks++;
    if (bus.drop_cnt_o !== 8'd1) begin
      errors++; $display("FAIL overflow_drop: got %0d, expected 1", bus.drop_cnt_o);
    end
    checks++;
    if (bus.rx_cnt_o !== 8'd7) begin
      errors++; $display("FAIL overflow_rx: got %0d, expected 7", bus.rx_cnt_o);
    end
  endtask

  task automatic test_pop_order();
    int n;
    do_reset();
    wr(2'd0, 2'd1); exp_q.push_back({2'd0, 2'd1});
    wr(2'd2, 2'd2); exp_q.push_back({2'd2, 2'd2});
    wr(2'd3, 2'd3); exp_q.push_back({2'd3, 2'd3});
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pop_order_timeout: got %0d pops pending, expected 0", exp_q.size());
    end
    checks++;
    if (first_pop_cyc != 10) begin
      errors++; $display("FAIL pop_latency: got first pop at cycle %0d, expected 10", first_pop_cyc);
    end
    checks++;
    if (bus.tx_cnt_o !== 8'd3 || bus.rx_cnt_o !== 8'd3) begin
      errors++; $display("FAIL pop_order_cnt: got tx %0d rx %0d, expected tx 3 rx 3",
                         bus.tx_cnt_o, bus.rx_cnt_o);
    end
    checks++;
    if ({bus.buf0_o, bus.buf1_o, bus.buf2_o, bus.buf3_o} !== 72'd0) begin
      errors++; $display("FAIL pop_order_bufs: got nonzero slot vectors, expected all 0");
    end
    checks++;
    if (bus.rd_buf_o !== 2'd3 || bus.rd_data_o !== 2'd3) begin
      errors++; $display("FAIL pop_order_held: got buf %0d data %0d, expected buf 3 data 3",
                         bus.rd_buf_o, bus.rd_data_o);
    end
  endtask

  task automatic test_pop_write_same();
    logic [1:0] d [6];
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) wr(2'd0, 2'(i % 4));
    repeat (3) @(negedge clk);
    d = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    checks++;
    if (bus.buf0_o !== pack(6, d)) begin
      errors++; $display("FAIL same_pre_buf0: got %h, expected %h", bus.buf0_o, pack(6, d));
    end
    exp_q.push_back({2'd0, 2'd0});
    wr(2'd0, 2'd3);
    n = 0;
    while (exp_q.size() != 0 && n < 5) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL same_timeout: got %0d pops pending, expected 0", exp_q.size());
    end
    d = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3};
    checks++;
    if (bus.buf0_o !== pack(6, d)) begin
      errors++; $display("FAIL same_buf0: got %h, expected %h", bus.buf0_o, pack(6, d));
    end
    checks++;
    if (bus.drop_cnt_o !== 8'd0 || bus.rx_cnt_o !== 8'd7 || bus.tx_cnt_o !== 8'd1) begin
      errors++; $display("FAIL same_cnt: got drop %0d rx %0d tx %0d, expected drop 0 rx 7 tx 1",
                         bus.drop_cnt_o, bus.rx_cnt_o, bus.tx_cnt_o);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] d1 [6];
    logic [1:0] d3 [6];
    int n1, n3, n;
    do_reset();
    wr(2'd1, 2'd1); wr(2'd1, 2'd2);
    wr(2'd3, 2'd0); wr(2'd3, 2'd1); wr(2'd3, 2'd2); wr(2'd3, 2'd3);
`ifdef BUFFER_SCHED_PRIORITY_READ_EN
    exp_q.push_back({2'd3, 2'd0});
    d1 = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0}; n1 = 2;
    d3 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0}; n3 = 3;
`else
    exp_q.push_back({2'd1, 2'd1});
    d1 = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; n1 = 1;
    d3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0}; n3 = 4;
`endif
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL arb_timeout: got %0d pops pending, expected 0", exp_q.size());
    end
    checks++;
    if (bus.buf1_o !== pack(n1, d1) || bus.buf3_o !== pack(n3, d3)) begin
      errors++; $display("FAIL arb_bufs: got buf1 %h buf3 %h, expected buf1 %h buf3 %h",
                         bus.buf1_o, bus.buf3_o, pack(n1, d1), pack(n3, d3));
    end
    checks++;
    if (bus.tx_cnt_o !== 8'd1) begin
      errors++; $display("FAIL arb_tx: got %0d, expected 1", bus.tx_cnt_o);
    end
  endtask

  task automatic test_reset_during_pop();
    logic [1:0] d [6];
    do_reset();
    wr(2'd1, 2'd2);
    repeat (8) @(negedge clk);
    d = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    checks++;
    if (bus.buf1_o !== pack(1, d)) begin
      errors++; $display("FAIL rst_pop_pre: got %h, expected %h", bus.buf1_o, pack(1, d));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.buf0_o, bus.buf1_o, bus.buf2_o, bus.buf3_o} !== 72'd0 ||
        {bus.tx_cnt_o, bus.rx_cnt_o, bus.drop_cnt_o} !== 24'd0) begin
      errors++; $display("FAIL rst_pop_clear: got buf1 %h rx %0d, expected all 0",
                         bus.buf1_o, bus.rx_cnt_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.rd_valid_o, bus.rd_buf_o, bus.rd_data_o} !== 5'd0) begin
      errors++; $display("FAIL rst_pop_rd: got %b, expected 0", {bus.rd_valid_o, bus.rd_buf_o, bus.rd_data_o});
    end
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    if (first_pop_cyc != -1 || bus.tx_cnt_o !== 8'd0) begin
      errors++; $display("FAIL rst_pop_none: got pop cycle %0d tx %0d, expected no pop",
                         first_pop_cyc, bus.tx_cnt_o);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    first_pop_cyc = -1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_buf    = 2'd0;
    bus.in_data   = 2'd0;
    test_reset();
    test_write_two();
    test_overflow();
    test_pop_order();
    test_pop_write_same();
    test_arbitration();
    test_reset_during_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
